regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32: register data width, even, at least 8.
REQ-002 Parameter ADDR_W, default 5: address width; depth is 2^ADDR_W.
REQ-003 Parameter LINK_REG, default 31: register written by the link port.
REQ-004 Parameter IO_A_REG, default 22: register mirrored on io_a_out.
REQ-005 Parameter IO_B_REG, default 23: register mirrored on io_b_out.
REQ-006 Ports:
- clk  in  1: the single clock; all state updates on the rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- raddr0, raddr1  in  ADDR_W: read addresses.
- rdata0, rdata1  out  DATA_W: read data.
- rbusy0, rbusy1  out  1: addressed register has a pending reservation.
- waddr  in  ADDR_W, wdata  in  DATA_W, wren  in  1: main write port.
- wmode  in  2: main write mode: 00 full, 01 upper, 10 low-merge, 11 reserved.
- jal_wren  in  1, jal_data  in  DATA_W: link write to LINK_REG.
- rsv_valid  in  1, rsv_addr  in  ADDR_W, rsv_ready  out  1: reservation handshake.
- rel_valid  in  1, rel_addr  in  ADDR_W, rel_data  in  DATA_W: release plus write-back.
- dbg_addr  in  ADDR_W, dbg_out  out  DATA_W: debug read tap.
- io_a_out, io_b_out  out  DATA_W: mirrors of IO_A_REG and IO_B_REG.
- busy_cnt  out  ADDR_W+1: number of busy registers.
- err  out  1: sticky protocol-error flag.

Function
REQ-007 Register 0 shall read as 0, ignore all writes, and never become busy.
REQ-008 Main write data shall be formed by wmode:
- 00: wdata.
- 01: wdata[DATA_W/2-1:0] placed in the upper half, lower half 0.
- 10: old upper half kept, lower half replaced by wdata[DATA_W/2-1:0].
REQ-009 A main write with wmode=11 shall be dropped and shall set err.
REQ-010 Reads (rdata0/1, dbg_out) shall be combinational with write-through bypass: each read returns the value the addressed register will hold after the current edge.
REQ-011 When several write sources target the same register in one cycle, priority shall be release, then link, then main; only the winner is written.
REQ-012 A main write to a busy register shall be dropped and shall set err, unless a release to that register occurs in the same cycle (release wins per REQ-011, no err).
REQ-013 rsv_ready shall equal: rsv_addr==0, or busy[rsv_addr]==0, or (rel_valid and rel_addr==rsv_addr).
REQ-014 A reservation is accepted on an edge where rsv_valid and rsv_ready; busy[rsv_addr] is then 1 from the next cycle; a reservation of register 0 is accepted with no state change.
REQ-015 A release clears busy[rel_addr] and writes rel_data, except when a reservation of the same address is accepted in the same cycle; then busy stays 1 and the data is still written.
REQ-016 A release to a non-busy register shall write the data, leave busy unchanged, and set err.
REQ-017 rbusy0/1 shall reflect the registered busy bits, without bypass.
REQ-018 busy_cnt shall equal the population count of busy bits, updated with them; the maximum is 2^ADDR_W-1.
REQ-019 io_a_out and io_b_out shall be the registered values of their registers, without bypass.
REQ-020 err, once set, shall stay set until reset.

Reset
REQ-021 While rst_n=0, all registers, busy bits, busy_cnt and err shall be 0, and all outputs shall read 0.
REQ-022 Assertion of rst_n shall abort outstanding reservations immediately.
REQ-023 After rst_n rises, the first state update shall occur on the next rising clk edge.

Verification
REQ-024 Upper write: wren, waddr=5, wdata=0x00001234, wmode=01 -> next cycle rdata0 = 0x12340000; then a low-merge write of 0xABCD -> 0x1234ABCD.
REQ-025 Bypass and priority: same cycle wren to 31 with 0x11, jal_wren with 0x22, raddr0=31 -> rdata0 = 0x22 in that cycle and after the edge.
REQ-026 Scoreboard: reserve reg 8 -> rbusy0=1 and busy_cnt=1; reserving 8 again -> rsv_ready=0; release 8 with 0xCAFE -> busy_cnt=0, reg 8 = 0xCAFE, err=0.
REQ-027 Simultaneous release and reserve of reg 8 -> rsv_ready=1, data written, busy stays 1, busy_cnt unchanged.
REQ-028 Error paths: a main write to busy reg 8, a release of idle reg 9, and wmode=11 each set err; reg 8 keeps its value; reg 0 stays 0 after any write.
REQ-029 Reset mid-operation with 3 reservations outstanding -> busy_cnt=0, err=0, io_a_out=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bundles the read, write, link, scoreboard and observation signals of regfile_sb.
// Ports:
//   master -- drives addresses, write data, and the reservation and release requests.
//   slave  -- the register file; drives read data, busy flags, mirrors, busy_cnt and err.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] raddr0;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              rbusy0;
  logic              rbusy1;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wren;
  logic [1:0]        wmode;
  logic              jal_wren;
  logic [DATA_W-1:0] jal_data;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_ready;
  logic              rel_valid;
  logic [ADDR_W-1:0] rel_addr;
  logic [DATA_W-1:0] rel_data;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_out;
  logic [DATA_W-1:0] io_a_out;
  logic [DATA_W-1:0] io_b_out;
  logic [ADDR_W:0]   busy_cnt;
  logic              err;

  modport master (
    output raddr0, raddr1, waddr, wdata, wren, wmode, jal_wren, jal_data,
           rsv_valid, rsv_addr, rel_valid, rel_addr, rel_data, dbg_addr,
    input  rdata0, rdata1, rbusy0, rbusy1, rsv_ready, dbg_out, io_a_out, io_b_out,
           busy_cnt, err
  );

  modport slave (
    input  raddr0, raddr1, waddr, wdata, wren, wmode, jal_wren, jal_data,
           rsv_valid, rsv_addr, rel_valid, rel_addr, rel_data, dbg_addr,
    output rdata0, rdata1, rbusy0, rbusy1, rsv_ready, dbg_out, io_a_out, io_b_out,
           busy_cnt, err
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with a busy-bit scoreboard, a link write port, a release/write-back port,
// bypassed combinational reads and a sticky protocol-error flag.
// Ports:
//   clk   -- clock, all state changes on the rising edge
//   rst_n -- asynchronous active-low reset
//   bus   -- regfile_sb_if slave: reads, main/link/release writes, reservations, debug tap,
//            IO mirrors, busy count and err
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LINK_REG = 31,
  parameter int unsigned IO_A_REG = 22,
  parameter int unsigned IO_B_REG = 23
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned HalfW = DATA_W / 2;
  localparam logic [ADDR_W-1:0] LinkIdx = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] IoAIdx  = ADDR_W'(IO_A_REG);
  localparam logic [ADDR_W-1:0] IoBIdx  = ADDR_W'(IO_B_REG);

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q;

  logic [DATA_W-1:0] main_data;
  logic              main_busy, rel_same_main, main_en, rsv_ok, rsv_acc, err_set;

  // Main-port data shaping; low-merge keeps the currently stored upper half.
  always_comb begin
    main_data = bus.wdata;
    case (bus.wmode)
      2'b01:   main_data = {bus.wdata[HalfW-1:0], {HalfW{1'b0}}};
      2'b10:   main_data = {regs_q[bus.waddr][DATA_W-1:HalfW], bus.wdata[HalfW-1:0]};
      default: main_data = bus.wdata;
    endcase
  end

  assign main_busy     = busy_q[bus.waddr];
  assign rel_same_main = bus.rel_valid && (bus.rel_addr == bus.waddr);
  assign main_en       = bus.wren && (bus.wmode != 2'b11) && !main_busy;

  // A release to the same address frees the slot in the same cycle.
  assign rsv_ok  = (bus.rsv_addr == '0) || !busy_q[bus.rsv_addr] ||
                   (bus.rel_valid && (bus.rel_addr == bus.rsv_addr));
  assign rsv_acc = bus.rsv_valid && rsv_ok && (bus.rsv_addr != '0);

  assign err_set = (bus.wren && (bus.wmode == 2'b11)) ||
                   (bus.wren && main_busy && !rel_same_main) ||
                   (bus.rel_valid && !busy_q[bus.rel_addr]);

  // Later assignments win: release over link over main.
  always_comb begin
    regs_d = regs_q;
    if (main_en)       regs_d[bus.waddr]    = main_data;
    if (bus.jal_wren)  regs_d[LinkIdx]      = bus.jal_data;
    if (bus.rel_valid) regs_d[bus.rel_addr] = bus.rel_data;
    regs_d[0] = '0;
  end

  // Clear-then-set so a same-address reserve keeps the bit high.
  always_comb begin
    busy_d = busy_q;
    if (bus.rel_valid) busy_d[bus.rel_addr] = 1'b0;
    if (rsv_acc)       busy_d[bus.rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_q | err_set;
    end
  end

  // Combinational outputs are forced to 0 while reset is held.
  assign bus.rdata0    = rst_n ? regs_d[bus.raddr0]   : '0;
  assign bus.rdata1    = rst_n ? regs_d[bus.raddr1]   : '0;
  assign bus.dbg_out   = rst_n ? regs_d[bus.dbg_addr] : '0;
  assign bus.rsv_ready = rst_n && rsv_ok;
  assign bus.rbusy0    = busy_q[bus.raddr0];
  assign bus.rbusy1    = busy_q[bus.raddr1];
  assign bus.io_a_out  = regs_q[IoAIdx];
  assign bus.io_b_out  = regs_q[IoBIdx];
  assign bus.busy_cnt  = cnt_q;
  assign bus.err       = err_q;
endmodule
